// File: rtl/mem_read_router_if.sv
// Bus interface for mem_read_router.
// Groups the control handshake (req/iord/wr/ready/done), the memory strobes and
// read data, and the IR/MDR outputs.
//   master : control unit / memory model side (drives req, iord, wr, mem_rdata)
//   slave  : the router (drives strobes, ready, done, ir_q, mdr_q)
// With ROUTER_REQ_ERR_EN defined, the sticky req_err flag is added to the bus.
interface mem_read_router_if #(
  parameter int unsigned DATA_W = 32
);

  logic              req;
  logic              iord;
  logic              wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
`ifdef ROUTER_REQ_ERR_EN
  logic              req_err;
`endif

  modport master (
`ifdef ROUTER_REQ_ERR_EN
    input  req_err,
`endif
    output req, iord, wr, mem_rdata,
    input  mem_rd_en, mem_wr_en, ready, done, ir_q, mdr_q
  );

  modport slave (
`ifdef ROUTER_REQ_ERR_EN
    output req_err,
`endif
    input  req, iord, wr, mem_rdata,
    output mem_rd_en, mem_wr_en, ready, done, ir_q, mdr_q
  );

endinterface

// File: rtl/mem_read_router.sv
// mem_read_router: sequences a memory access and steers the returned word to
// the Instruction Register (iord=0, fetch) or the Memory Data Register (iord=1).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_read_router_if.slave: req/iord/wr/mem_rdata in;
//            mem_rd_en/mem_wr_en/ready/done/ir_q/mdr_q out
// Optional feature macro ROUTER_REQ_ERR_EN: adds sticky bus.req_err, set by a
// req seen while ready=0, cleared only by reset.
// All outputs are registered; strobes/ready/done are computed from next state.
module mem_read_router #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mem_read_router_if.slave       bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dest_q, dest_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  // Next-state, capture and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    wr_d    = wr_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    ready_d = 1'b1;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request directly so back-to-back accesses skip IDLE
        if (bus.req) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          dest_d  = bus.iord;
          wr_d    = bus.wr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!wr_q) begin
            if (dest_q) mdr_d = bus.mem_rdata;
            else        ir_d  = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs registered one edge early so they align with the state they describe
    rd_en_d = (state_d == S_ACCESS) && !wr_d;
    wr_en_d = (state_d == S_ACCESS) && wr_d && (cnt_d == '0)
              && (state_q != S_ACCESS);
    ready_d = (state_d != S_ACCESS);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dest_q  <= 1'b0;
      wr_q    <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      wr_q    <= wr_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef ROUTER_REQ_ERR_EN
  logic req_err_q;

  // Sticky flag for requests issued while busy; does not affect the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_err_q <= 1'b0;
    end else if (bus.req && !ready_q) begin
      req_err_q <= 1'b1;
    end
  end

  assign bus.req_err = req_err_q;
`endif

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.ir_q      = ir_q;
  assign bus.mdr_q     = mdr_q;

endmodule

// File: tb/tb_mem_read_router.sv
// Directed bench for mem_read_router: a LAT=2 instance for fetch/data/write/
// busy/abort sequences and a LAT=1 instance for back-to-back alternating reads.
module tb_mem_read_router;

  logic clk;
  logic reset_n;
  int   nchk;
  int   npass;

  mem_read_router_if #(.DATA_W(32)) bus  ();
  mem_read_router_if #(.DATA_W(32)) bus1 ();

  mem_read_router #(.DATA_W(32), .LAT(2), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  mem_read_router #(.DATA_W(32), .LAT(1), .CNT_W(4)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    clk = 1'b0;
    nchk = 0;
    npass = 0;
    reset_n = 1'b1;
    bus.req = 1'b0;  bus.iord = 1'b0;  bus.wr = 1'b0;  bus.mem_rdata = '0;
    bus1.req = 1'b0; bus1.iord = 1'b0; bus1.wr = 1'b0; bus1.mem_rdata = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_ir",    bus.ir_q, 32'd0);
    check("rst_mdr",   bus.mdr_q, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Fetch, LAT=2
    bus.req = 1'b1; bus.iord = 1'b0; bus.wr = 1'b0; bus.mem_rdata = 32'h8C010004;
    tick();
    bus.req = 1'b0;
    check("f_c1_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("f_c1_ready", 32'(bus.ready), 32'd0);
    check("f_c1_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("f_c1_done",  32'(bus.done), 32'd0);
    tick();
    check("f_c2_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("f_c2_done",  32'(bus.done), 32'd0);
    tick();
    check("f_c3_done",  32'(bus.done), 32'd1);
    check("f_c3_ready", 32'(bus.ready), 32'd1);
    check("f_c3_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("f_ir",       bus.ir_q, 32'h8C010004);
    check("f_mdr",      bus.mdr_q, 32'd0);
    tick();
    check("f_idle_done", 32'(bus.done), 32'd0);

    // Data read then back-to-back fetch
    bus.req = 1'b1; bus.iord = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    check("d_done", 32'(bus.done), 32'd1);
    check("d_mdr",  bus.mdr_q, 32'hDEADBEEF);
    check("d_ir",   bus.ir_q, 32'h8C010004);
    bus.req = 1'b1; bus.iord = 1'b0; bus.mem_rdata = 32'h11112222;
    tick();
    bus.req = 1'b0;
    check("b2b_ready", 32'(bus.ready), 32'd0);
    check("b2b_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("b2b_done",  32'(bus.done), 32'd0);
    tick();
    tick();
    check("b2b_done2", 32'(bus.done), 32'd1);
    check("b2b_ir",    bus.ir_q, 32'h11112222);
    check("b2b_mdr",   bus.mdr_q, 32'hDEADBEEF);
    tick();

    // Write access
    bus.req = 1'b1; bus.iord = 1'b1; bus.wr = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.req = 1'b0; bus.wr = 1'b0;
    check("w_c1_wr_en", 32'(bus.mem_wr_en), 32'd1);
    check("w_c1_rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    check("w_c2_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("w_c2_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("w_c2_ready", 32'(bus.ready), 32'd0);
    tick();
    check("w_done", 32'(bus.done), 32'd1);
    check("w_ir",   bus.ir_q, 32'h11112222);
    check("w_mdr",  bus.mdr_q, 32'hDEADBEEF);
    tick();

    // Busy request during ACCESS is ignored
`ifdef ROUTER_REQ_ERR_EN
    check("e_pre_req_err", 32'(bus.req_err), 32'd0);
`endif
    bus.req = 1'b1; bus.iord = 1'b1; bus.wr = 1'b0; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.iord = 1'b0; bus.wr = 1'b1;
    tick();
    bus.req = 1'b0;
    check("e_ready", 32'(bus.ready), 32'd0);
    check("e_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("e_wr_en", 32'(bus.mem_wr_en), 32'd0);
`ifdef ROUTER_REQ_ERR_EN
    check("e_req_err", 32'(bus.req_err), 32'd1);
`endif
    tick();
    check("e_done", 32'(bus.done), 32'd1);
    check("e_mdr",  bus.mdr_q, 32'hCAFEF00D);
    check("e_ir",   bus.ir_q, 32'h11112222);
    bus.wr = 1'b0;
    tick();
    check("e_idle_ready", 32'(bus.ready), 32'd1);

    // Abort in first ACCESS cycle
    bus.req = 1'b1; bus.iord = 1'b0; bus.mem_rdata = 32'hBADBAD00;
    tick();
    bus.req = 1'b0;
    check("a_rd_en", 32'(bus.mem_rd_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("a_rd_en_drop", 32'(bus.mem_rd_en), 32'd0);
    check("a_ready", 32'(bus.ready), 32'd1);
    check("a_done",  32'(bus.done), 32'd0);
    check("a_ir",    bus.ir_q, 32'd0);
    check("a_mdr",   bus.mdr_q, 32'd0);
`ifdef ROUTER_REQ_ERR_EN
    check("a_req_err", 32'(bus.req_err), 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    tick();
    check("a_post_done", 32'(bus.done), 32'd0);
    tick();
    check("a_post_done2", 32'(bus.done), 32'd0);
    check("a_post_ir",    bus.ir_q, 32'd0);

    // LAT=1: back-to-back reads alternating destination, data 1..4
    for (int k = 0; k < 4; k++) begin
      bus1.req = 1'b1;
      bus1.iord = 1'(k % 2);
      bus1.mem_rdata = 32'(k + 1);
      tick();
      bus1.req = 1'b0;
      check("l1_acc_done",  32'(bus1.done), 32'd0);
      check("l1_acc_rd_en", 32'(bus1.mem_rd_en), 32'd1);
      tick();
      check("l1_done", 32'(bus1.done), 32'd1);
    end
    check("l1_ir",  bus1.ir_q, 32'd3);
    check("l1_mdr", bus1.mdr_q, 32'd4);
    tick();
    check("l1_idle_done",  32'(bus1.done), 32'd0);
    check("l1_idle_ready", 32'(bus1.ready), 32'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
